// File: rtl/ldm_mem_seq_if.sv
// rtl/ldm_mem_seq_if.sv - word-wide req/ack data-memory port driven by ldm_mem_seq
interface ldm_mem_seq_if #(
  parameter int ADDR_W = 32
);
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_ack;
  logic [31:0]       i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/ldm_mem_seq.sv
// rtl/ldm_mem_seq.sv - LDM/STM memory sequencer: beat FIFO, one req/ack access per beat, load writeback
// Optional base-register writeback state is built when LDM_BASE_WB_EN is defined.
module ldm_mem_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          i_ldm_mem_vld,
  input  logic [31:0]   i_ldm_offset,
  input  logic [3:0]    i_ldm_reg_code,
  input  logic          i_ldm_l,
  input  logic          i_ldm_last,
  input  logic [31:0]   i_base,
  input  logic [31:0]   i_store_data,
  output logic          o_seq_full,
  ldm_mem_seq_if.master mem,
  output logic          o_rf_we,
  output logic [3:0]    o_rf_waddr,
  output logic [31:0]   o_rf_wdata,
  output logic          o_pc_load,
  output logic          o_done,
  input  logic          i_ldm_w,
  input  logic [3:0]    i_base_code,
  input  logic [31:0]   i_wb_base
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        code;
    logic              l;
    logic              last;
    logic [31:0]       data;
  } beat_t;

`ifdef LDM_BASE_WB_EN
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
`else
  typedef enum logic {IDLE, REQ} state_t;
`endif

  state_t           state_q;
  beat_t            fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  beat_t            in_beat, head, next_head;
  logic             push, pop, push_ok;

  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rf_we_q, pc_load_q, done_q;
  logic [3:0]        rf_waddr_q;
  logic [31:0]       rf_wdata_q;

`ifdef LDM_BASE_WB_EN
  logic        first_q, wb_w_q, base_hit_q;
  logic [3:0]  base_code_q;
  logic [31:0] wb_base_q;

  assign push_ok = (state_q != WB);

  // Writeback parameters belong to the instruction whose first beat is pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q     <= 1'b1;
      wb_w_q      <= 1'b0;
      base_code_q <= '0;
      wb_base_q   <= '0;
    end else if (push) begin
      first_q <= i_ldm_last;
      if (first_q) begin
        wb_w_q      <= i_ldm_w;
        base_code_q <= i_base_code;
        wb_base_q   <= i_wb_base;
      end
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{i_ldm_w, i_base_code, i_wb_base};
  assign push_ok   = 1'b1;
`endif

  always_comb begin
    in_beat.addr = ADDR_W'((i_base + i_ldm_offset) & 32'hFFFF_FFFC);
    in_beat.code = i_ldm_reg_code;
    in_beat.l    = i_ldm_l;
    in_beat.last = i_ldm_last;
    in_beat.data = i_store_data;
    head         = fifo_q[rd_ptr_q];
    // A lone head popped while a beat arrives: the arriving beat becomes the next request.
    next_head    = (count_q > CNT_W'(1)) ? fifo_q[rd_ptr_q + PTR_W'(1)] : in_beat;
    pop          = (state_q == REQ) & mem.i_mem_ack;
    push         = en & i_ldm_mem_vld & ~full_q & push_ok;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= in_beat;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_load_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef LDM_BASE_WB_EN
      base_hit_q <= 1'b0;
`endif
    end else begin
      rf_we_q   <= 1'b0;
      pc_load_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != '0 && en) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= ~head.l;
            addr_q  <= head.addr;
            wdata_q <= head.data;
          end
        end
        REQ: begin
          if (mem.i_mem_ack) begin
            if (head.l) begin
              rf_wdata_q <= mem.i_mem_rdata;
              if (head.code == 4'hF) begin
                pc_load_q <= 1'b1;
              end else begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= head.code;
              end
            end
`ifdef LDM_BASE_WB_EN
            if (head.l && head.code == base_code_q) base_hit_q <= 1'b1;
            if (head.last && wb_w_q) begin
              state_q <= WB;
              req_q   <= 1'b0;
              we_q    <= 1'b0;
            end else begin
              if (head.last) base_hit_q <= 1'b0;
`endif
              done_q <= head.last;
              if (en && (count_q > CNT_W'(1) || push)) begin
                we_q    <= ~next_head.l;
                addr_q  <= next_head.addr;
                wdata_q <= next_head.data;
              end else begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                we_q    <= 1'b0;
              end
`ifdef LDM_BASE_WB_EN
            end
`endif
          end
        end
`ifdef LDM_BASE_WB_EN
        WB: begin
          // A base register that was itself loaded keeps the loaded value.
          if (!base_hit_q) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= base_code_q;
            rf_wdata_q <= wb_base_q;
          end
          done_q     <= 1'b1;
          base_hit_q <= 1'b0;
          state_q    <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_seq_full      = full_q;
  assign mem.o_mem_req   = req_q;
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;
  assign o_rf_we         = rf_we_q;
  assign o_rf_waddr      = rf_waddr_q;
  assign o_rf_wdata      = rf_wdata_q;
  assign o_pc_load       = pc_load_q;
  assign o_done          = done_q;
endmodule
